// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state type and mid-bit helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: rx synchroniser, frame FSM, mid-bit sampler
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err_pulse,
    output logic       start_edge,
    output logic       idle
);

    localparam int HALF = half_bit(CLKS_PER_BIT);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
    assign idle       = (state == IDLE);
    assign byte_data  = shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta         <= 1'b1;
            rx_sync         <= 1'b1;
            rx_prev         <= 1'b1;
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            rx_meta         <= rx;
            rx_sync         <= rx_meta;
            rx_prev         <= rx_sync;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        // a start bit that is high again at mid-bit was only a glitch
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_sync) byte_valid      <= 1'b1;
                        else         frame_err_pulse <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART program loader: word assembly, timeout, mode control, program RAM
module uart_prog_loader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int WORD_BYTES   = 2,
    parameter int ADDR_W       = 8,
    parameter int HOLD_CYCLES  = 13500000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rx,
    input  logic                    button,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    mode,
    output logic [ADDR_W:0]         load_count,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int DW       = 8 * WORD_BYTES;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int BIW      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam int HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [BIW-1:0]  LAST_LANE = BIW'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0] FULL      = (ADDR_W + 1)'(DEPTH);
    localparam logic [TW-1:0]   TO_HIT    = TW'(TO_LIMIT - 1);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0]   HOLD_HIT  = HW'(HOLD_CYCLES - 1);

    logic           rst_meta;
    logic           rst_n_sync;
    logic           btn_meta;
    logic           btn_sync;
    logic [7:0]     byte_data;
    logic           byte_valid;
    logic           frame_err_pulse;
    logic           start_edge;
    logic           rx_idle;
    logic [BIW-1:0] byte_idx;
    logic [DW-1:0]  word_buf;
    logic [DW-1:0]  word_next;
    logic [TW-1:0]  to_cnt;
    logic [HW-1:0]  hold_cnt;
    logic           word_done;
    logic           toggle;
    logic           timeout_hit;
    logic           we;
    logic [DW-1:0]  mem [DEPTH];

    // reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {rst_n_sync, rst_meta} <= 2'b00;
        else          {rst_n_sync, rst_meta} <= {rst_meta, 1'b1};
    end

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clk),
        .reset_n         (rst_n_sync),
        .rx              (rx),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .frame_err_pulse (frame_err_pulse),
        .start_edge      (start_edge),
        .idle            (rx_idle)
    );

    always_comb begin
        word_next = word_buf;
        word_next[{byte_idx, 3'b000} +: 8] = byte_data;
    end

    assign word_done   = byte_valid && (byte_idx == LAST_LANE);
    assign toggle      = !btn_sync && (hold_cnt == HOLD_HIT);
    assign timeout_hit = (to_cnt == TO_HIT);
    assign we          = !toggle && word_done && !mode && (load_count != FULL);

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            btn_meta   <= 1'b1;
            btn_sync   <= 1'b1;
            hold_cnt   <= '0;
            to_cnt     <= '0;
            mode       <= 1'b0;
            byte_idx   <= '0;
            word_buf   <= '0;
            load_count <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;

            // saturating at HOLD_CYCLES means one toggle per press
            if (btn_sync)                  hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;

            if (byte_idx != '0 && rx_idle && !start_edge && !timeout_hit)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;

            if (toggle) begin
                mode     <= !mode;
                byte_idx <= '0;
                if (mode) begin
                    load_count <= '0;
                    frame_err  <= 1'b0;
                    overflow   <= 1'b0;
                end
            end else if (frame_err_pulse) begin
                frame_err <= 1'b1;
                byte_idx  <= '0;
            end else if (byte_valid) begin
                word_buf <= word_next;
                byte_idx <= word_done ? '0 : byte_idx + 1'b1;
                if (word_done && !mode) begin
                    if (load_count == FULL) overflow   <= 1'b1;
                    else                    load_count <= load_count + 1'b1;
                end
            end else if (timeout_hit) begin
                byte_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[load_count[ADDR_W-1:0]] <= word_next;
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) rd_data <= '0;
        else             rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - randomized self-checking bench with a word-level reference model
module tb_uart_prog_loader;

    localparam int CPB   = 16;
    localparam int WB    = 2;
    localparam int AW    = 4;
    localparam int HOLD  = 8;
    localparam int TOB   = 20;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic          button = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic [15:0]   rd_data;
    logic          mode;
    logic [AW:0]   load_count;
    logic          frame_err;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] mm [DEPTH];
    bit          mv [DEPTH];
    int          m_count, m_idx;
    bit          m_mode, m_ferr, m_ovf;
    logic [15:0] m_word;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .WORD_BYTES   (WB),
        .ADDR_W       (AW),
        .HOLD_CYCLES  (HOLD),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .button     (button),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .mode       (mode),
        .load_count (load_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            m_ferr = 1;
            m_idx  = 0;
        end else begin
            m_word[m_idx*8 +: 8] = b;
            m_idx++;
            if (m_idx == WB) begin
                m_idx = 0;
                if (!m_mode) begin
                    if (m_count == DEPTH) m_ovf = 1;
                    else begin
                        mm[m_count] = m_word;
                        mv[m_count] = 1;
                        m_count++;
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        model_byte(b, stop_ok);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0], 1);
        send_byte(w[15:8], 1);
    endtask

    task automatic idle_bits(input int bits);
        repeat (bits * CPB) @(negedge clk);
        if (bits >= TOB) m_idx = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        button  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        m_count = 0; m_idx = 0; m_mode = 0; m_ferr = 0; m_ovf = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".mode"},       32'(mode),       32'(m_mode));
        check_val({tag, ".load_count"}, 32'(load_count), 32'(m_count));
        check_val({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
        check_val({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    endtask

    task automatic read_check(input string tag, input int addr);
        @(negedge clk);
        rd_addr = AW'(addr);
        @(negedge clk);
        if (mv[addr]) check_val(tag, 32'(rd_data), 32'(mm[addr]));
    endtask

    task automatic hold_button(input string tag, input int clocks);
        bit prev;
        int flips, first;
        prev  = mode;
        flips = 0;
        first = -1;
        button = 1'b0;
        for (int i = 0; i < clocks; i++) begin
            @(negedge clk);
            if (mode != prev) begin
                flips++;
                if (first < 0) first = i;
            end
            prev = mode;
        end
        button = 1'b1;
        repeat (4) @(negedge clk);
        check_val({tag, ".flips"}, 32'(flips), 32'd1);
        check_val({tag, ".toggle_time"}, 32'(first >= HOLD && first <= HOLD + 4), 32'd1);
        m_mode = !m_mode;
        m_idx  = 0;
        if (!m_mode) begin
            m_count = 0; m_ferr = 0; m_ovf = 0;
        end
    endtask

    initial begin
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) mv[i] = 0;
        do_reset();
        check_outputs("reset");
        check_val("reset.rd_data", 32'(rd_data), 32'd0);

        send_byte(8'h34, 1);
        send_byte(8'h12, 1);
        check_outputs("first_word");
        read_check("first_word.mem0", 0);
        check_val("first_word.value", 32'(rd_data), 32'h1234);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_outputs("glitch");
        send_word(16'hABCD);
        read_check("glitch.align", 1);

        send_byte(8'h34, 1);
        send_byte(8'h55, 0);
        check_outputs("frame_err");
        send_word(16'h5678);
        read_check("frame_err.align", 2);

        send_byte(8'hAA, 1);
        idle_bits(TOB + 2);
        send_byte(8'h78, 1);
        send_byte(8'h56, 1);
        check_outputs("timeout");
        read_check("timeout.mem3", 3);
        check_val("timeout.value", 32'(rd_data), 32'h5678);

        do_reset();
        send_word(16'h0001);
        for (int i = 1; i < DEPTH + 1; i++) send_word(16'($urandom));
        check_outputs("overflow");
        read_check("overflow.mem0", 0);
        check_val("overflow.value", 32'(rd_data), 32'h0001);
        for (int i = 0; i < 4; i++) read_check("overflow.rand", int'($urandom_range(DEPTH - 1)));

        hold_button("to_run", 100);
        check_outputs("run");
        for (int i = 0; i < 3; i++) send_word(16'($urandom));
        send_byte(8'h3C, 0);
        check_outputs("run.words");
        read_check("run.mem0", 0);
        hold_button("to_load", 100);
        check_outputs("load_again");

        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            send_byte(b, ($urandom_range(7) != 0));
            if ($urandom_range(7) == 0) idle_bits(TOB + 3);
            else if ($urandom_range(1) == 0) idle_bits(1);
        end
        check_outputs("random");
        for (int i = 0; i < DEPTH; i++) read_check("random.mem", i);

        rx = 1'b0;
        repeat (CPB * 5) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        m_count = 0; m_idx = 0; m_mode = 0; m_ferr = 0; m_ovf = 0;
        check_outputs("midreset");
        check_val("midreset.rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        check_outputs("after_reset");
        read_check("after_reset.mem0", 0);
        check_val("after_reset.value", 32'(rd_data), 32'h2211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
